// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : noc_pkg
// Description : Shared flit and arbiter-state definitions for the NoC router.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_W   = 9;
    localparam int TAIL_BIT = FLIT_W - 1;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    function automatic logic is_tail(input flit_t f);
        return f[TAIL_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/merge2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : merge2_arbiter_if
// Description : Two input flit streams and one merged output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface merge2_arbiter_if;
    import noc_pkg::*;

    flit_t in0_data;
    logic  in0_valid;
    logic  in0_ready;
    flit_t in1_data;
    logic  in1_valid;
    logic  in1_ready;
    flit_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  out_src;

    // master: the merge block itself; slave: the surrounding sources and sink
    modport master (
        input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
        output in0_ready, in1_ready, out_data, out_valid, out_src
    );

    modport slave (
        output in0_data, in0_valid, in1_data, in1_valid, out_ready,
        input  in0_ready, in1_ready, out_data, out_valid, out_src
    );

endinterface
`default_nettype wire

// File: rtl/flit_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : flit_skid_buffer
// Description : Two-entry FIFO with valid/ready on both sides and a registered
//               has-space flag used as the upstream ready.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_skid_buffer #(
    parameter int WIDTH = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_in_data,
    input  wire logic             i_in_valid,
    output      logic             o_in_ready,
    output      logic [WIDTH-1:0] o_out_data,
    output      logic             o_out_valid,
    input  wire logic             i_out_ready
);

    logic [WIDTH-1:0] r_mem_q [2];
    logic [WIDTH-1:0] w_mem_d [2];
    logic             r_wr_ptr_q, w_wr_ptr_d;
    logic             r_rd_ptr_q, w_rd_ptr_d;
    logic [1:0]       r_count_q,  w_count_d;
    logic             r_space_q,  w_space_d;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_in_valid && r_space_q;
    assign w_pop  = (r_count_q != 2'd0) && i_out_ready;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = i_in_data;
            w_wr_ptr_d          = ~r_wr_ptr_q;
        end
        if (w_pop) begin
            w_rd_ptr_d = ~r_rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
        // Space reflects the occupancy after this edge, so a full buffer
        // deasserts ready in the very next cycle.
        w_space_d = (w_count_d < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_q[0] <= '0;
            r_mem_q[1] <= '0;
            r_wr_ptr_q <= 1'b0;
            r_rd_ptr_q <= 1'b0;
            r_count_q  <= 2'd0;
            r_space_q  <= 1'b1;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_space_q  <= w_space_d;
        end
    end

    assign o_in_ready  = r_space_q;
    assign o_out_valid = (r_count_q != 2'd0);
    assign o_out_data  = r_mem_q[r_rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/merge2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : merge2_arbiter
// Description : Two-input wormhole merge, packet-granular round-robin, with a
//               two-entry output skid buffer carrying {src, flit}.
// Revision    : 1.0 - initial release
// ============================================================================
module merge2_arbiter
    import noc_pkg::*;
(
    input wire logic           CLK,
    input wire logic           RESET,
    merge2_arbiter_if.master   bus
);

    arb_state_t r_state_q, w_state_d;
    logic       r_prio_q,  w_prio_d;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_req;
    logic       w_space;
    logic       w_push;
    logic       w_sel_src;
    flit_t      w_sel_flit;
    logic [FLIT_W:0] w_buf_in;
    logic [FLIT_W:0] w_buf_out;
    logic       w_buf_valid;

    // Grant is combinational so a head flit transfers in its first cycle.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (bus.in0_valid && (!bus.in1_valid || !r_prio_q)) begin
                    w_grant0 = 1'b1;
                end else if (bus.in1_valid) begin
                    w_grant1 = 1'b1;
                end
            end
            LOCK0:   w_grant0 = 1'b1;
            LOCK1:   w_grant1 = 1'b1;
            default: begin
                w_grant0 = 1'b0;
                w_grant1 = 1'b0;
            end
        endcase
    end

    assign w_req      = (w_grant0 && bus.in0_valid) || (w_grant1 && bus.in1_valid);
    assign w_push     = w_req && w_space;
    assign w_sel_src  = w_grant1;
    assign w_sel_flit = w_grant1 ? bus.in1_data : bus.in0_data;
    assign w_buf_in   = {w_sel_src, w_sel_flit};

    always_comb begin
        w_state_d = r_state_q;
        w_prio_d  = r_prio_q;
        if (w_push) begin
            if (is_tail(w_sel_flit)) begin
                w_state_d = IDLE;
                w_prio_d  = ~w_sel_src;
            end else begin
                w_state_d = w_sel_src ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q <= IDLE;
            r_prio_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_prio_q  <= w_prio_d;
        end
    end

    flit_skid_buffer #(
        .WIDTH (FLIT_W + 1)
    ) u_out_buf (
        .clk         (CLK),
        .rst         (RESET),
        .i_in_data   (w_buf_in),
        .i_in_valid  (w_req),
        .o_in_ready  (w_space),
        .o_out_data  (w_buf_out),
        .o_out_valid (w_buf_valid),
        .i_out_ready (bus.out_ready)
    );

    // Outputs read as zero throughout the reset cycle itself.
    assign bus.in0_ready = w_grant0 && w_space && !RESET;
    assign bus.in1_ready = w_grant1 && w_space && !RESET;
    assign bus.out_valid = w_buf_valid && !RESET;
    assign bus.out_data  = RESET ? '0 : w_buf_out[FLIT_W-1:0];
    assign bus.out_src   = RESET ? 1'b0 : w_buf_out[FLIT_W];

endmodule
`default_nettype wire

// File: doc/merge2_arbiter.md
# merge2_arbiter

Clocked two-input wormhole merge that sits directly downstream of the 1-to-2 flit decoder stage in the NoC router. It takes the decoder's Out0/Out1 flit streams from two neighbouring decoders, arbitrates round-robin at packet granularity, and emits one merged 9-bit flit stream. Once a packet is granted, it stays locked until its tail flit passes. This block is the synchronous counterpart used in the clocked co-simulation build of the router.

## Interface
- FLIT_W, 9: flit width; bit FLIT_W-1 is the tail flag, bits FLIT_W-2:0 are payload.
- CLK  input  1  the single clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- in0_data  input  FLIT_W  flit from source 0.
- in0_valid  input  1  source 0 flit present.
- in0_ready  output  1  source 0 flit accepted this cycle when high with in0_valid.
- in1_data, in1_valid, in1_ready: same as above, for source 1.
- out_data  output  FLIT_W  merged flit.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_src  output  1  index of the input that supplied the current out_data.

## Operation
- A transfer on any port occurs when valid and ready are both high at a rising edge. Data is held stable while valid is high and ready is low; the producer must not drop valid.
- Arbitration FSM states:
  - IDLE: no packet in progress.
  - LOCK0: packet from in0 in progress.
  - LOCK1: packet from in1 in progress.
- IDLE grant rule: if exactly one input is valid, grant it. If both are valid, grant the input equal to the `prio` bit. The grant is combinational, so the head flit transfers in the same cycle.
- On a granted head-flit transfer:
  - tail=0: go to LOCK(g).
  - tail=1 (single-flit packet): stay in IDLE and set prio to !g.
- In LOCK(g): only in(g)_ready may be high. A transfer with tail=1 returns the FSM to IDLE and sets prio to !g. The other input is starved until then.
- inX_ready = granted(X) && buffer_has_space. An ungranted input always sees ready=0.
- Output stage: 2-entry skid buffer (FIFO).
  - buffer_has_space is a registered signal, equal to (occupancy < 2) after the current edge's update.
  - Entries hold {src, flit}.
  - out_valid = occupancy != 0. out_data and out_src come from the head entry.
- Simultaneous push and pop in the same cycle: occupancy is unchanged and order is preserved. A push while full cannot occur because ready is low.
- No payload transformation; flits pass bit-exact.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, in0_ready=0, in1_ready=0 during the RESET cycle. Internal reset values: state=IDLE, prio=0, occupancy=0.
- RESET asserted mid-packet discards buffered flits and the lock. The first cycle after reset is treated as IDLE. Upstream must restart packets.
- Latency: a flit accepted at edge N is visible on out_data after edge N (in cycle N+1). out_valid rises 1 cycle after the first accept.
- Throughput: 1 flit/cycle sustained while out_ready=1.
- Backpressure: if out_ready is low with occupancy 2, both in*_ready read 0 from the next cycle. Recovery: one pop restores ready on the following cycle.
- Switchover: the tail of packet A and the head of packet B from the other input can transfer on consecutive cycles. There is no bubble between packets.
- Both inputs valid in IDLE with prio=1: in1 is served first.

## Structure
- Shared package noc_pkg, containing:
  - FLIT_W=9 and TAIL_BIT=FLIT_W-1 constants.
  - flit_t typedef (logic [FLIT_W-1:0]).
  - arb_state_t enum {IDLE, LOCK0, LOCK1}.
- Sub-module flit_skid_buffer (2-entry, parameterised width, valid/ready both sides) instantiated once for the output stage. The arbiter FSM and ready logic live in merge2_arbiter.

## Test plan
- Single source: in0 sends a 3-flit packet 0x001, 0x002, 0x103 (tail) with out_ready=1. Required: out_data is 0x001, 0x002, 0x103 on consecutive cycles starting one cycle after the first accept; out_src=0; in1_ready stays 0.
- Contention from reset: both inputs valid with single-flit packets 0x1AA (in0) and 0x1BB (in1). Required order out: 0x1AA, 0x1BB, 0x1AA, …, alternating, with prio starting at 0.
- Lock: in0 starts a 4-flit packet; in1 asserts valid mid-packet. Required: in1 flit appears only after in0's tail, immediately on the next cycle, with no bubble.
- Backpressure: out_ready=0 for 5 cycles during a packet. Required: at most 2 flits are accepted; in0_ready falls; no flit is lost or duplicated after out_ready returns.
- Reset mid-packet: assert RESET for 1 cycle while in LOCK1 with 2 flits buffered. Required: out_valid=0 next cycle; a new in0 head is granted immediately afterwards.
- Random: random valid/ready toggling over 10k cycles, checked against a scoreboard. Required: per-source order preserved, packets never interleaved on out, every flit delivered exactly once.
